multicycle_alu: RTL and testbench

//  Parametrised, handshaked ALU for the RISC-V datapath. Single-cycle logic/arith/shift ops

---
 rtl/multicycle_alu_if.sv | 22 ++
 rtl/multicycle_alu.sv | 129 ++++++++++++
 tb/tb_multicycle_alu.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/result handshake bundle for multicycle_alu
interface multicycle_alu_if #(parameter int WIDTH = 32);
  logic             inValid;
  logic             inReady;
  logic [3:0]       operation;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             zeroFlag;
  logic             divByZero;
  logic             illegalOp;
  modport master (
    output inValid, operation, operand1, operand2, outReady,
    input  inReady, outValid, result, zeroFlag, divByZero, illegalOp
  );
  modport slave (
    input  inValid, operation, operand1, operand2, outReady,
    output inReady, outValid, result, zeroFlag, divByZero, illegalOp
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU with single-cycle ops plus iterative shift-add multiply and restoring divide
module multicycle_alu #(
  parameter int WIDTH         = 32,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_alu_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t           state, state_n;
  logic [SW-1:0]    cnt, cnt_n, sh;
  logic [WIDTH-1:0] a, a_n, b, b_n, acc, acc_n, res, res_n, alu, mul_acc, rem_new, quo_new;
  logic [WIDTH:0]   sub;
  logic             rem_op, rem_op_n, ld, zf, dz, dz_n, il, il_n, ill, last, is_div;
  assign sh      = bus.operand2[SW-1:0];
  assign is_div  = bus.operation == 4'h3 || bus.operation == 4'hC;
  assign ill     = bus.operation > 4'hC || (!ENABLE_MULDIV && (bus.operation == 4'h2 || is_div));
  assign last    = cnt == SW'(WIDTH - 1);
  assign mul_acc = acc + (b[0] ? a : '0);
  assign sub     = {acc, a[WIDTH-1]} - {1'b0, b};
  assign rem_new = sub[WIDTH] ? {acc[WIDTH-2:0], a[WIDTH-1]} : sub[WIDTH-1:0];
  assign quo_new = {a[WIDTH-2:0], ~sub[WIDTH]};
  assign bus.inReady   = state == IDLE;
  assign bus.outValid  = state == DONE;
  assign bus.result    = res;
  assign bus.zeroFlag  = zf;
  assign bus.divByZero = dz;
  assign bus.illegalOp = il;
  always_comb begin
    case (bus.operation)
      4'h0:    alu = bus.operand1 + bus.operand2;
      4'h1:    alu = bus.operand1 - bus.operand2;
      4'h4:    alu = bus.operand1 << sh;
      4'h5:    alu = bus.operand1 >> sh;
      4'h6:    alu = $signed(bus.operand1) >>> sh;
      4'h7:    alu = bus.operand1 & bus.operand2;
      4'h8:    alu = bus.operand1 | bus.operand2;
      4'h9:    alu = bus.operand1 ^ bus.operand2;
      4'hA:    alu = {{(WIDTH-1){1'b0}}, $signed(bus.operand1) < $signed(bus.operand2)};
      4'hB:    alu = {{(WIDTH-1){1'b0}}, bus.operand1 < bus.operand2};
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    a_n      = a;
    b_n      = b;
    acc_n    = acc;
    rem_op_n = rem_op;
    res_n    = res;
    dz_n     = dz;
    il_n     = il;
    ld       = 1'b0;
    case (state)
      IDLE: if (bus.inValid) begin
        a_n      = bus.operand1;
        b_n      = bus.operand2;
        acc_n    = '0;
        cnt_n    = '0;
        rem_op_n = bus.operation == 4'hC;
        dz_n     = 1'b0;
        il_n     = ill;
        if (ill) begin
          state_n = DONE;
          ld      = 1'b1;
          res_n   = '0;
        end else if (bus.operation == 4'h2) begin
          state_n = MUL;
        end else if (is_div) begin
          state_n = bus.operand2 == '0 ? DONE : DIV;
          ld      = bus.operand2 == '0;
          dz_n    = bus.operand2 == '0;
          res_n   = bus.operand2 != '0 ? res : bus.operation == 4'hC ? bus.operand1 : '1;
        end else begin
          state_n = DONE;
          ld      = 1'b1;
          res_n   = alu;
        end
      end
      MUL: begin
        acc_n   = mul_acc;
        a_n     = a << 1;
        b_n     = b >> 1;
        cnt_n   = cnt + 1'b1;
        state_n = last ? DONE : MUL;
        ld      = last;
        res_n   = last ? mul_acc : res;
      end
      DIV: begin
        acc_n   = rem_new;
        a_n     = quo_new;
        cnt_n   = cnt + 1'b1;
        state_n = last ? DONE : DIV;
        ld      = last;
        res_n   = !last ? res : rem_op ? rem_new : quo_new;
      end
      DONE:    state_n = bus.outReady ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      rem_op <= 1'b0;
      res    <= '0;
      zf     <= 1'b0;
      dz     <= 1'b0;
      il     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      a      <= a_n;
      b      <= b_n;
      acc    <= acc_n;
      rem_op <= rem_op_n;
      res    <= res_n;
      zf     <= ld ? res_n == '0 : zf;
      dz     <= dz_n;
      il     <= il_n;
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed self-checking bench for multicycle_alu at WIDTH=32
module tb_multicycle_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  multicycle_alu_if #(.WIDTH(32)) bus ();
  multicycle_alu #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, output int lat);
    bus.operation = op;
    bus.operand1  = x;
    bus.operand2  = y;
    bus.inValid   = 1'b1;
    @(posedge clk);
    #1;
    bus.inValid   = 1'b0;
    bus.operation = 4'h0;
    bus.operand1  = 32'hDEAD_BEEF;
    bus.operand2  = 32'h1234_5678;
    lat = 1;
    while (!bus.outValid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic retire;
    bus.outReady = 1'b1;
    @(posedge clk);
    #1;
    bus.outReady = 1'b0;
  endtask
  task automatic test_op(input string name, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input int elat, input logic [31:0] eres, input logic ez, input logic edz, input logic eil);
    int lat;
    issue(op, x, y, lat);
    checks++; if (lat !== elat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat); end
    checks++; if (bus.result !== eres) begin errors++; $display("FAIL %s result: got %h want %h", name, bus.result, eres); end
    checks++; if (bus.zeroFlag !== ez) begin errors++; $display("FAIL %s zeroFlag: got %b want %b", name, bus.zeroFlag, ez); end
    checks++; if (bus.divByZero !== edz) begin errors++; $display("FAIL %s divByZero: got %b want %b", name, bus.divByZero, edz); end
    checks++; if (bus.illegalOp !== eil) begin errors++; $display("FAIL %s illegalOp: got %b want %b", name, bus.illegalOp, eil); end
    checks++; if (bus.inReady !== 1'b0) begin errors++; $display("FAIL %s inReady in DONE: got %b want 0", name, bus.inReady); end
    retire;
    checks++; if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0) begin errors++; $display("FAIL %s retire: inReady=%b outValid=%b want 1 0", name, bus.inReady, bus.outValid); end
  endtask
  task automatic test_reset;
    bus.inValid   = 1'b0;
    bus.outReady  = 1'b0;
    bus.operation = 4'h0;
    bus.operand1  = '0;
    bus.operand2  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset outValid: got %b want 0", bus.outValid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 0", bus.result); end
    checks++; if ({bus.zeroFlag, bus.divByZero, bus.illegalOp} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b want 000", {bus.zeroFlag, bus.divByZero, bus.illegalOp}); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL reset inReady: got %b want 1", bus.inReady); end
  endtask
  task automatic test_single;
    test_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b1, 1'b0, 1'b0);
    test_op("sub",      4'h1, 32'h5, 32'h7, 1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    test_op("sll_mask", 4'h4, 32'h1, 32'h21, 1, 32'h2, 1'b0, 1'b0, 1'b0);
    test_op("sll_31",   4'h4, 32'h1, 32'h1F, 1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    test_op("sra",      4'h6, 32'h8000_0000, 32'h24, 1, 32'hF800_0000, 1'b0, 1'b0, 1'b0);
    test_op("srl",      4'h5, 32'h8000_0000, 32'h24, 1, 32'h0800_0000, 1'b0, 1'b0, 1'b0);
    test_op("and",      4'h7, 32'hF0F0, 32'hFF00, 1, 32'hF000, 1'b0, 1'b0, 1'b0);
    test_op("or",       4'h8, 32'hF0F0, 32'hFF00, 1, 32'hFFF0, 1'b0, 1'b0, 1'b0);
    test_op("xor",      4'h9, 32'hF0F0, 32'hFF00, 1, 32'h0FF0, 1'b0, 1'b0, 1'b0);
    test_op("slt",      4'hA, 32'hFFFF_FFFF, 32'h1, 1, 32'h1, 1'b0, 1'b0, 1'b0);
    test_op("sltu",     4'hB, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_mul;
    int lat;
    issue(4'h2, 32'hF, 32'h10, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul latency: got %0d want 33", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.outValid !== 1'b1 || bus.result !== 32'hF0 || bus.inReady !== 1'b0) begin errors++; $display("FAIL mul hold %0d: outValid=%b result=%h inReady=%b want 1 f0 0", i, bus.outValid, bus.result, bus.inReady); end
      @(posedge clk);
      #1;
    end
    retire;
    checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL mul retire inReady: got %b want 1", bus.inReady); end
    test_op("mul_ones", 4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1, 1'b0, 1'b0, 1'b0);
    test_op("mul_neg",  4'h2, 32'hFFFF_FFFD, 32'h5, 33, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0);
    test_op("mul_zero", 4'h2, 32'h1234_5678, 32'h0, 33, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_div;
    test_op("divu",      4'h3, 32'hFFFF, 32'h0F0F, 33, 32'h11, 1'b0, 1'b0, 1'b0);
    test_op("remu",      4'hC, 32'hFFFF, 32'h0F0F, 33, 32'h0, 1'b1, 1'b0, 1'b0);
    test_op("divu_100",  4'h3, 32'd100, 32'd7, 33, 32'd14, 1'b0, 1'b0, 1'b0);
    test_op("remu_100",  4'hC, 32'd100, 32'd7, 33, 32'd2, 1'b0, 1'b0, 1'b0);
    test_op("divu_big",  4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 1'b1, 1'b0, 1'b0);
    test_op("remu_big",  4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    test_op("divu_by1",  4'h3, 32'hFFFF_FFFF, 32'h1, 33, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_div_zero;
    test_op("divu_z", 4'h3, 32'h7, 32'h0, 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    test_op("remu_z", 4'hC, 32'h7, 32'h0, 1, 32'h7, 1'b0, 1'b1, 1'b0);
    test_op("remu_0z", 4'hC, 32'h0, 32'h0, 1, 32'h0, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic test_illegal;
    test_op("ill_d", 4'hD, 32'h5, 32'h6, 1, 32'h0, 1'b1, 1'b0, 1'b1);
    test_op("ill_f", 4'hF, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b1, 1'b0, 1'b1);
    test_op("add_after_ill", 4'h0, 32'h2, 32'h3, 1, 32'h5, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back;
    bus.operation = 4'h0;
    bus.operand1  = 32'h1;
    bus.operand2  = 32'h2;
    bus.inValid   = 1'b1;
    bus.outReady  = 1'b1;
    @(posedge clk);
    #1;
    bus.operand1 = 32'h4;
    bus.operand2 = 32'h5;
    checks++; if (bus.outValid !== 1'b1 || bus.result !== 32'h3 || bus.inReady !== 1'b0) begin errors++; $display("FAIL b2b first: outValid=%b result=%h inReady=%b want 1 3 0", bus.outValid, bus.result, bus.inReady); end
    @(posedge clk);
    #1;
    checks++; if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin errors++; $display("FAIL b2b gap: outValid=%b inReady=%b want 0 1", bus.outValid, bus.inReady); end
    @(posedge clk);
    #1;
    bus.inValid = 1'b0;
    checks++; if (bus.outValid !== 1'b1 || bus.result !== 32'h9) begin errors++; $display("FAIL b2b second: outValid=%b result=%h want 1 9", bus.outValid, bus.result); end
    @(posedge clk);
    #1;
    bus.outReady = 1'b0;
  endtask
  task automatic test_reset_midmul;
    bus.operation = 4'h2;
    bus.operand1  = 32'hF;
    bus.operand2  = 32'h10;
    bus.inValid   = 1'b1;
    @(posedge clk);
    #1;
    bus.inValid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (bus.outValid !== 1'b0 || bus.inReady !== 1'b0) begin errors++; $display("FAIL midmul busy: outValid=%b inReady=%b want 0 0", bus.outValid, bus.inReady); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (bus.inReady !== 1'b1 || bus.outValid !== 1'b0 || bus.result !== 32'h0) begin errors++; $display("FAIL midmul reset: inReady=%b outValid=%b result=%h want 1 0 0", bus.inReady, bus.outValid, bus.result); end
    test_op("ill_after_reset", 4'hF, 32'h0, 32'h0, 1, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask
  initial begin
    test_reset;
    test_single;
    test_mul;
    test_div;
    test_div_zero;
    test_illegal;
    test_back_to_back;
    test_single;
    test_reset_midmul;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
